audio_mixer: RTL

AUDIO_MIXER -- requirements
Module: audio_mixer

---
 rtl/audio_mixer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: multi-channel stereo mixer with per-channel Q1.7 gain and mute.
// A next_sample strobe snapshots all inputs; one channel is accumulated per
// cycle, then both sums are saturated to OUT_W bits and registered.
// Ports:
//   clk, rst          - clock, async active-high reset
//   next_sample       - strobe starting a mix (ignored while busy -> overrun)
//   in_left/in_right  - packed signed samples, channel n at [n*IN_W +: IN_W]
//   gain              - packed unsigned Q1.7 gains, channel n at [n*8 +: 8]
//   mute              - per-channel mute mask
//   clip_clear        - clears sticky clip/overrun flags
//   out_left/right    - registered saturated mix, held between out_valid
//   out_valid         - one-cycle pulse on output update
//   busy              - mix in progress
//   clip_left/right   - sticky saturation flags
//   overrun           - sticky: strobe arrived while busy
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 23,
  parameter int OUT_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   next_sample,
  input  logic [NUM_CH*IN_W-1:0] in_left,
  input  logic [NUM_CH*IN_W-1:0] in_right,
  input  logic [NUM_CH*8-1:0]    gain,
  input  logic [NUM_CH-1:0]      mute,
  input  logic                   clip_clear,
  output logic [OUT_W-1:0]       out_left,
  output logic [OUT_W-1:0]       out_right,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   clip_left,
  output logic                   clip_right,
  output logic                   overrun
);
  localparam int IDXW = $clog2(NUM_CH);
  localparam int AW   = IN_W + 2 + IDXW;
  // Compare width wide enough to hold both the accumulator and the OUT_W limits.
  localparam int CW   = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT} state_t;
  state_t r_state, w_next;

  logic [NUM_CH*IN_W-1:0] r_left, r_right;
  logic [NUM_CH*8-1:0]    r_gain;
  logic [NUM_CH-1:0]      r_mute;
  logic [IDXW-1:0]        r_idx;
  logic signed [AW-1:0]   r_acc_l, r_acc_r;

  logic [IN_W-1:0]          w_smp_l, w_smp_r;
  logic [7:0]               w_gain;
  logic                     w_mute;
  logic signed [IN_W+8:0]   w_prod_l, w_prod_r;
  logic signed [AW-1:0]     w_term_l, w_term_r;
  logic signed [CW-1:0]     w_ext_l, w_ext_r;
  logic                     w_hi_l, w_lo_l, w_hi_r, w_lo_r;
  logic [OUT_W-1:0]         w_sat_l, w_sat_r;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (next_sample) w_next = S_ACCUM;
      S_ACCUM: if (r_idx == IDXW'(NUM_CH-1)) w_next = S_SAT;
      S_SAT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Current channel operands from the snapshot.
  assign w_smp_l = r_left[r_idx*IN_W +: IN_W];
  assign w_smp_r = r_right[r_idx*IN_W +: IN_W];
  assign w_gain  = r_gain[r_idx*8 +: 8];
  assign w_mute  = r_mute[r_idx];

  assign w_prod_l = $signed(w_smp_l) * $signed({1'b0, w_gain});
  assign w_prod_r = $signed(w_smp_r) * $signed({1'b0, w_gain});

  // Dropping the low 7 bits of a two's-complement product is floor(x/128).
  assign w_term_l = w_mute ? '0 : {{(AW-IN_W-2){w_prod_l[IN_W+8]}}, w_prod_l[IN_W+8:7]};
  assign w_term_r = w_mute ? '0 : {{(AW-IN_W-2){w_prod_r[IN_W+8]}}, w_prod_r[IN_W+8:7]};

  assign w_ext_l = {{(CW-AW){r_acc_l[AW-1]}}, r_acc_l};
  assign w_ext_r = {{(CW-AW){r_acc_r[AW-1]}}, r_acc_r};
  assign w_hi_l  = (w_ext_l > MAXV);
  assign w_lo_l  = (w_ext_l < MINV);
  assign w_hi_r  = (w_ext_r > MAXV);
  assign w_lo_r  = (w_ext_r < MINV);
  assign w_sat_l = w_hi_l ? MAXV[OUT_W-1:0] : (w_lo_l ? MINV[OUT_W-1:0] : w_ext_l[OUT_W-1:0]);
  assign w_sat_r = w_hi_r ? MAXV[OUT_W-1:0] : (w_lo_r ? MINV[OUT_W-1:0] : w_ext_r[OUT_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left     <= '0;
      r_right    <= '0;
      r_gain     <= '0;
      r_mute     <= '0;
      r_idx      <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (next_sample) begin
          r_left  <= in_left;
          r_right <= in_right;
          r_gain  <= gain;
          r_mute  <= mute;
          r_idx   <= '0;
          r_acc_l <= '0;
          r_acc_r <= '0;
        end
        S_ACCUM: begin
          r_acc_l <= r_acc_l + w_term_l;
          r_acc_r <= r_acc_r + w_term_r;
          r_idx   <= r_idx + IDXW'(1);
        end
        S_SAT: begin
          out_left  <= w_sat_l;
          out_right <= w_sat_r;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      // Clear first so a same-cycle set takes priority.
      if (clip_clear) begin
        clip_left  <= 1'b0;
        clip_right <= 1'b0;
        overrun    <= 1'b0;
      end
      if (r_state == S_SAT && (w_hi_l || w_lo_l)) clip_left  <= 1'b1;
      if (r_state == S_SAT && (w_hi_r || w_lo_r)) clip_right <= 1'b1;
      if (next_sample && r_state != S_IDLE)       overrun    <= 1'b1;
    end
  end
endmodule
